// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: grants whole frames round-robin across NUM_CH async_fifo read ports
// and merges them into one valid/ready stream tagged with the source channel.

module fifo_rd_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int CH_WIDTH        = $clog2(NUM_CH),
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic                         rd_clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_CH-1:0]            ch_en_i,
    input  logic [NUM_CH-1:0]            fifo_empty_i,
    output logic [NUM_CH-1:0]            fifo_rd_en_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [DATA_WIDTH-1:0]        m_data_o,
    output logic                         m_last_o,
    output logic [CH_WIDTH-1:0]          m_ch_o,
    output logic                         busy_o,
    output logic                         err_len_o
);
    localparam int CNT_WIDTH = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [CH_WIDTH-1:0]   ch;
    } entry_t;

    state_t                state, state_nxt;
    logic [CH_WIDTH-1:0]   grant, grant_nxt;
    logic [CH_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]  word_cnt, word_cnt_nxt;
    logic                  rd_pending;

    entry_t                obuf [2];
    logic                  rd_idx, wr_idx;
    logic [1:0]            occ, occ_nxt;

    logic [NUM_CH-1:0]     req, req_hi, pick;
    logic [CH_WIDTH-1:0]   arb_ch;
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [DATA_WIDTH-1:0] arr_word;
    logic                  arrive, at_limit, frame_end, pop, issue;
    entry_t                arr_entry;

    assign req = ~fifo_empty_i & ch_en_i;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        req_hi = '0;
        arb_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_hi[i] = req[i] && (i >= int'(rr_ptr));
        end
        pick = (req_hi != '0) ? req_hi : req;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick[i]) arb_ch = CH_WIDTH'(i);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k] = fifo_rd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A read issued last cycle returns now; one-cycle FIFO latency means at most one in flight.
    assign arr_word  = ch_data[grant];
    assign arrive    = rd_pending;
    assign at_limit  = (word_cnt == CNT_WIDTH'(MAX_FRAME_WORDS));
    assign frame_end = arrive && (arr_word[DATA_WIDTH-1] || at_limit);
    assign pop       = m_valid_o && m_ready_i;
    assign occ_nxt   = occ + {1'b0, arrive} - {1'b0, pop};
    assign issue     = (state == XFER) && !fifo_empty_i[grant] && !frame_end &&
                       !at_limit && (occ_nxt <= 2'd1);

    always_comb begin
        arr_entry.data = {arr_word[DATA_WIDTH-1] | at_limit, arr_word[DATA_WIDTH-2:0]};
        arr_entry.last = arr_word[DATA_WIDTH-1] | at_limit;
        arr_entry.ch   = grant;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        word_cnt_nxt = word_cnt;
        fifo_rd_en_o = '0;
        case (state)
            IDLE: begin
                word_cnt_nxt = '0;
                if (req != '0) begin
                    state_nxt  = XFER;
                    grant_nxt  = arb_ch;
                    rr_ptr_nxt = (arb_ch == CH_WIDTH'(NUM_CH - 1)) ? '0 : arb_ch + CH_WIDTH'(1);
                end
            end
            XFER: begin
                if (issue) begin
                    fifo_rd_en_o[grant] = 1'b1;
                    word_cnt_nxt        = word_cnt + CNT_WIDTH'(1);
                end
                if (frame_end) begin
                    state_nxt    = IDLE;
                    word_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            word_cnt   <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            rr_ptr     <= rr_ptr_nxt;
            word_cnt   <= word_cnt_nxt;
            rd_pending <= issue;
        end
    end

    always_ff @(posedge rd_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the buffer entries are reset because m_data_o/m_ch_o read them directly.
            for (int i = 0; i < 2; i++) obuf[i] <= '0;
            rd_idx <= 1'b0;
            wr_idx <= 1'b0;
            occ    <= '0;
        end else begin
            if (arrive) begin
                obuf[wr_idx] <= arr_entry;
                wr_idx       <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            occ <= occ_nxt;
        end
    end

    assign m_valid_o = (occ != 2'd0);
    assign m_data_o  = obuf[rd_idx].data;
    assign m_last_o  = obuf[rd_idx].last;
    assign m_ch_o    = obuf[rd_idx].ch;
    assign busy_o    = (state == XFER);
    assign err_len_o = arrive && at_limit && !arr_word[DATA_WIDTH-1];

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: behavioural 1-cycle-latency FIFOs per channel,
// an output monitor, and one task per scenario comparing against hand-derived streams.

module tb_fifo_rd_arbiter;
    localparam int NUM_CH = 4;
    localparam int DW     = 64;
    localparam int CHW    = 2;
    localparam int MAXW   = 8;
    localparam int DEPTH  = 64;

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [CHW-1:0] ch;
        int             cyc;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    ch_en = '1;
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    fifo_rd_en;
    logic [NUM_CH*DW-1:0] fifo_rd_data;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [DW-1:0]        m_data;
    logic                 m_last;
    logic [CHW-1:0]       m_ch;
    logic                 busy;
    logic                 err_len;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_WIDTH(CHW), .MAX_FRAME_WORDS(MAXW)
    ) dut (
        .rd_clk_i(clk), .rstn_i(rst_n), .ch_en_i(ch_en), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(fifo_rd_en), .fifo_rd_data_i(fifo_rd_data), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last), .m_ch_o(m_ch),
        .busy_o(busy), .err_len_o(err_len)
    );

    // Behavioural FIFOs: pushed[] written by the stimulus, popped[] by the read model.
    logic [DW-1:0] mem [NUM_CH][DEPTH];
    int            pushed [NUM_CH] = '{default: 0};
    int            popped [NUM_CH] = '{default: 0};
    logic [DW-1:0] rd_data [NUM_CH];
    int            cyc = 0;
    int            underrun_cnt = 0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
        assign fifo_empty[k] = (pushed[k] == popped[k]);
        assign fifo_rd_data[k*DW +: DW] = rd_data[k];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fifo_rd_en[k]) begin
                if (pushed[k] == popped[k]) begin
                    underrun_cnt <= underrun_cnt + 1;
                end else begin
                    rd_data[k] <= mem[k][popped[k] % DEPTH];
                    popped[k]  <= popped[k] + 1;
                end
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    obs_t           got_q [$];
    int             rd_cnt [NUM_CH] = '{default: 0};
    int             err_cnt = 0;
    int             onehot_viol = 0;
    int             stab_viol = 0;
    int             max_occ = 0;
    logic           hold_prev = 1'b0;
    logic [DW-1:0]  prev_data;
    logic           prev_last;
    logic [CHW-1:0] prev_ch;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM_CH; k++) rd_cnt[k] <= rd_cnt[k] + int'(fifo_rd_en[k]);
            if ($countones(fifo_rd_en) > 1) onehot_viol <= onehot_viol + 1;
            if (err_len) err_cnt <= err_cnt + 1;
            if (int'(dut.occ) > max_occ) max_occ <= int'(dut.occ);
            if (hold_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last ||
                              m_ch !== prev_ch))
                stab_viol <= stab_viol + 1;
            hold_prev <= m_valid && !m_ready;
            prev_data <= m_data;
            prev_last <= m_last;
            prev_ch   <= m_ch;
            if (m_valid && m_ready) got_q.push_back('{m_data, m_last, m_ch, cyc});
        end else begin
            hold_prev <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk(int ch, int idx, logic last);
        mk = {last, 7'd0, 8'(ch), 48'(idx)};
    endfunction

    function automatic obs_t ex(int ch, int idx, logic last);
        ex.data = mk(ch, idx, last);
        ex.last = last;
        ex.ch   = CHW'(ch);
        ex.cyc  = 0;
    endfunction

    task automatic push_word(int ch, int idx, logic last);
        mem[ch][pushed[ch] % DEPTH] = mk(ch, idx, last);
        pushed[ch] = pushed[ch] + 1;
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_got(int n, int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) cycles(1);
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && (busy || m_valid); i++) cycles(1);
        cycles(2);
    endtask

    task automatic test_reset;
        cycles(3);
        total++;
        if ({m_valid, m_last, busy, err_len, fifo_rd_en, m_ch, m_data} !== '0)
            $display("FAIL reset_outputs: got valid=%b last=%b busy=%b err=%b rd_en=%b ch=%0d data=%h, expected all 0",
                     m_valid, m_last, busy, err_len, fifo_rd_en, m_ch, m_data);
        else passed++;
        rst_n = 1'b1;
        cycles(2);
        total++;
        if ({busy, m_valid, fifo_rd_en} !== '0)
            $display("FAIL reset_idle: got busy=%b valid=%b rd_en=%b, expected 0 0 0000", busy, m_valid, fifo_rd_en);
        else passed++;
    endtask

    task automatic test_round_robin;
        obs_t exp_q [$];
        int   base;
        int   rd0 [NUM_CH];
        m_ready = 1'b1;
        base = got_q.size();
        rd0  = rd_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
            push_word(c, 0, 1'b0);
            push_word(c, 1, 1'b1);
            exp_q.push_back(ex(c, 0, 1'b0));
            exp_q.push_back(ex(c, 1, 1'b1));
        end
        wait_got(base + 8, 200);
        wait_idle(50);
        // Refill only ch0 and ch3; rr_ptr has wrapped to 0.
        push_word(3, 5, 1'b0);
        push_word(3, 6, 1'b1);
        push_word(0, 5, 1'b0);
        push_word(0, 6, 1'b1);
        exp_q.push_back(ex(0, 5, 1'b0));
        exp_q.push_back(ex(0, 6, 1'b1));
        exp_q.push_back(ex(3, 5, 1'b0));
        exp_q.push_back(ex(3, 6, 1'b1));
        wait_got(base + 12, 200);
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 12)
            $display("FAIL rr_count: got %0d words, expected 12", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 12 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== exp_q[i].data || got_q[base+i].last !== exp_q[i].last ||
                got_q[base+i].ch !== exp_q[i].ch)
                $display("FAIL rr_word %0d: got data=%h last=%b ch=%0d, expected data=%h last=%b ch=%0d",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         exp_q[i].data, exp_q[i].last, exp_q[i].ch);
            else passed++;
        end
        total++;
        if (rd_cnt[0] - rd0[0] !== 4 || rd_cnt[1] - rd0[1] !== 2 || rd_cnt[2] - rd0[2] !== 2 ||
            rd_cnt[3] - rd0[3] !== 4)
            $display("FAIL rr_reads: got %0d %0d %0d %0d, expected 4 2 2 4", rd_cnt[0] - rd0[0],
                     rd_cnt[1] - rd0[1], rd_cnt[2] - rd0[2], rd_cnt[3] - rd0[3]);
        else passed++;
    endtask

    task automatic test_single_frame;
        int base;
        int c0;
        int rd0;
        m_ready = 1'b1;
        base = got_q.size();
        rd0  = rd_cnt[2];
        c0   = cyc;
        push_word(2, 10, 1'b0);
        push_word(2, 11, 1'b0);
        push_word(2, 12, 1'b1);
        wait_got(base + 3, 50);
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 3)
            $display("FAIL single_count: got %0d words, expected 3", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== mk(2, 10 + i, i == 2) || got_q[base+i].last !== (i == 2) ||
                got_q[base+i].ch !== 2'd2 || got_q[base+i].cyc !== c0 + 3 + i)
                $display("FAIL single_word %0d: got data=%h last=%b ch=%0d cycle=%0d, expected data=%h last=%b ch=2 cycle=%0d",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         got_q[base+i].cyc - c0, mk(2, 10 + i, i == 2), i == 2, 3 + i);
            else passed++;
        end
        total++;
        if (rd_cnt[2] - rd0 !== 3 || busy !== 1'b0)
            $display("FAIL single_reads: got reads=%0d busy=%b, expected reads=3 busy=0", rd_cnt[2] - rd0, busy);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        int         base;
        int         rd0;
        int         err0;
        pat  = 4'b1001;
        base = got_q.size();
        rd0  = rd_cnt[1];
        err0 = err_cnt;
        for (int i = 0; i < 8; i++) push_word(1, 40 + i, i == 7);
        for (int i = 0; i < 200 && got_q.size() < base + 8; i++) begin
            m_ready = pat[i % 4];
            cycles(1);
        end
        m_ready = 1'b1;
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 8)
            $display("FAIL bp_count: got %0d words, expected 8", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 8 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== mk(1, 40 + i, i == 7) || got_q[base+i].last !== (i == 7) ||
                got_q[base+i].ch !== 2'd1)
                $display("FAIL bp_word %0d: got data=%h last=%b ch=%0d, expected data=%h last=%b ch=1",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         mk(1, 40 + i, i == 7), i == 7);
            else passed++;
        end
        total++;
        if (rd_cnt[1] - rd0 !== 8 || err_cnt - err0 !== 0)
            $display("FAIL bp_reads: got reads=%0d err=%0d, expected reads=8 err=0", rd_cnt[1] - rd0, err_cnt - err0);
        else passed++;
        total++;
        if (max_occ > 2 || stab_viol !== 0 || underrun_cnt !== 0 || onehot_viol !== 0)
            $display("FAIL bp_integrity: got max_occ=%0d unstable=%0d underruns=%0d multi_rd=%0d, expected <=2 0 0 0",
                     max_occ, stab_viol, underrun_cnt, onehot_viol);
        else passed++;
    endtask

    task automatic test_empty_stall;
        int base;
        int rd0;
        int stall_bad;
        m_ready   = 1'b1;
        stall_bad = 0;
        base = got_q.size();
        rd0  = rd_cnt[1];
        push_word(1, 60, 1'b0);
        push_word(1, 61, 1'b0);
        for (int i = 0; i < 30 && rd_cnt[1] - rd0 < 2; i++) cycles(1);
        cycles(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== '0 || busy !== 1'b1) stall_bad++;
        end
        total++;
        if (stall_bad !== 0)
            $display("FAIL stall_hold: got %0d bad cycles (rd_en high or busy low), expected 0", stall_bad);
        else passed++;
        cycles(1);
        push_word(1, 62, 1'b0);
        push_word(1, 63, 1'b0);
        push_word(1, 64, 1'b1);
        wait_got(base + 5, 50);
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 5 || rd_cnt[1] - rd0 !== 5)
            $display("FAIL stall_count: got words=%0d reads=%0d, expected 5 5", got_q.size() - base, rd_cnt[1] - rd0);
        else passed++;
        for (int i = 0; i < 5 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== mk(1, 60 + i, i == 4) || got_q[base+i].last !== (i == 4) ||
                got_q[base+i].ch !== 2'd1)
                $display("FAIL stall_word %0d: got data=%h last=%b ch=%0d, expected data=%h last=%b ch=1",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         mk(1, 60 + i, i == 4), i == 4);
            else passed++;
        end
    endtask

    task automatic test_length_limit;
        obs_t exp_q [$];
        int   base;
        int   rd3;
        int   err0;
        m_ready = 1'b1;
        base = got_q.size();
        rd3  = rd_cnt[3];
        err0 = err_cnt;
        for (int i = 0; i < 10; i++) push_word(3, i, 1'b0);
        push_word(0, 20, 1'b0);
        push_word(0, 21, 1'b1);
        for (int i = 0; i < 7; i++) exp_q.push_back(ex(3, i, 1'b0));
        exp_q.push_back(ex(3, 7, 1'b1));
        exp_q.push_back(ex(0, 20, 1'b0));
        exp_q.push_back(ex(0, 21, 1'b1));
        exp_q.push_back(ex(3, 8, 1'b0));
        exp_q.push_back(ex(3, 9, 1'b0));
        exp_q.push_back(ex(3, 10, 1'b1));
        wait_got(base + 12, 100);
        total++;
        if (err_cnt - err0 !== 1)
            $display("FAIL len_err_pulse: got %0d cycles of err_len, expected 1", err_cnt - err0);
        else passed++;
        push_word(3, 10, 1'b1);
        wait_got(base + 13, 50);
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 13 || rd_cnt[3] - rd3 !== 11)
            $display("FAIL len_count: got words=%0d ch3_reads=%0d, expected 13 11", got_q.size() - base, rd_cnt[3] - rd3);
        else passed++;
        for (int i = 0; i < 13 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== exp_q[i].data || got_q[base+i].last !== exp_q[i].last ||
                got_q[base+i].ch !== exp_q[i].ch)
                $display("FAIL len_word %0d: got data=%h last=%b ch=%0d, expected data=%h last=%b ch=%0d",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         exp_q[i].data, exp_q[i].last, exp_q[i].ch);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_frame;
        obs_t exp_q [$];
        int   base;
        int   rd0;
        m_ready = 1'b0;
        base = got_q.size();
        rd0  = rd_cnt[0];
        for (int i = 0; i < 6; i++) push_word(0, 80 + i, i == 5);
        for (int i = 0; i < 30 && rd_cnt[0] - rd0 < 2; i++) cycles(1);
        cycles(3);
        total++;
        if (busy !== 1'b1 || m_valid !== 1'b1 || rd_cnt[0] - rd0 !== 2)
            $display("FAIL rstmid_pre: got busy=%b valid=%b reads=%0d, expected 1 1 2", busy, m_valid, rd_cnt[0] - rd0);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_valid, m_last, busy, err_len, fifo_rd_en, m_ch, m_data} !== '0)
            $display("FAIL rstmid_outputs: got valid=%b last=%b busy=%b err=%b rd_en=%b ch=%0d data=%h, expected all 0",
                     m_valid, m_last, busy, err_len, fifo_rd_en, m_ch, m_data);
        else passed++;
        push_word(2, 30, 1'b0);
        push_word(2, 31, 1'b1);
        cycles(2);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 2; i < 6; i++) exp_q.push_back(ex(0, 80 + i, i == 5));
        exp_q.push_back(ex(2, 30, 1'b0));
        exp_q.push_back(ex(2, 31, 1'b1));
        wait_got(base + 6, 100);
        wait_idle(50);
        total++;
        if (got_q.size() - base !== 6)
            $display("FAIL rstmid_count: got %0d words, expected 6", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 6 && base + i < got_q.size(); i++) begin
            total++;
            if (got_q[base+i].data !== exp_q[i].data || got_q[base+i].last !== exp_q[i].last ||
                got_q[base+i].ch !== exp_q[i].ch)
                $display("FAIL rstmid_word %0d: got data=%h last=%b ch=%0d, expected data=%h last=%b ch=%0d",
                         i, got_q[base+i].data, got_q[base+i].last, got_q[base+i].ch,
                         exp_q[i].data, exp_q[i].last, exp_q[i].ch);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_frame;
        test_backpressure;
        test_empty_stall;
        test_length_limit;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
